sr04_distance_filter: RTL and testbench

- Downstream stage of the SR04 ranging controller; sits between the controller's 12-bit distance output and the FND display driver.
- Range-checks each new measurement and maintains a moving average over the last 2^AVG_LOG2 in-range samples.
- Converts the average to 4-digit packed BCD with a sequential double-dabble engine, one shift per clock.
- Replaces the raw binary path to the display with a filtered, display-ready value plus status flags.

---
 rtl/sr04_distance_filter.sv | 170 +++++++++++++++++
 tb/tb_sr04_distance_filter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sr04_distance_filter.sv
// SR04 distance post-filter: range check, moving average over the last
// 2^AVG_LOG2 accepted samples, and sequential binary-to-BCD conversion.
module sr04_distance_filter #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned MIN_CM   = 2,
  parameter int unsigned MAX_CM   = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_dist_valid,
  input  logic [11:0] i_distance,
  output logic [11:0] o_distance,
  output logic [15:0] o_bcd,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_out_of_range
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = 12 + AVG_LOG2;
  localparam int unsigned CntW  = AVG_LOG2 + 1;

  localparam logic [11:0]     MinCm   = 12'(MIN_CM);
  localparam logic [11:0]     MaxCm   = 12'(MAX_CM);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StUpdate  = 2'd1;
  localparam logic [1:0] StConvert = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [11:0]         sample_q, sample_d;
  logic [11:0]         buf_q [Depth];
  logic [11:0]         buf_d [Depth];
  logic [SumW-1:0]     sum_q, sum_d;
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [11:0]         filt_q, filt_d;
  logic [11:0]         bin_q, bin_d;
  logic [15:0]         bcd_q, bcd_d;
  logic [3:0]          iter_q, iter_d;
  logic [11:0]         dist_q, dist_d;
  logic [15:0]         bcd_out_q, bcd_out_d;
  logic                valid_q, valid_d;
  logic                oor_q, oor_d;

  logic                in_range;
  logic [SumW-1:0]     sum_upd;
  logic [CntW-1:0]     count_upd;
  logic [11:0]         filt_upd;
  logic [15:0]         bcd_adj;
  logic [15:0]         bcd_sh;
  logic [11:0]         bin_sh;

  // Window update candidates for the latched sample, plus one double-dabble step.
  always_comb begin
    in_range  = (sample_q >= MinCm) && (sample_q <= MaxCm);
    sum_upd   = sum_q - SumW'(buf_q[wr_ptr_q]) + SumW'(sample_q);
    count_upd = (count_q == CntFull) ? count_q : count_q + 1'b1;
    // Pass raw samples through until the window holds a full set.
    filt_upd  = (count_upd < CntFull) ? sample_q : 12'(sum_upd >> AVG_LOG2);

    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[14:0], bin_q[11]};
    bin_sh = {bin_q[10:0], 1'b0};
  end

  // Next-state logic for the IDLE/UPDATE/CONVERT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    buf_d     = buf_q;
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    filt_d    = filt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    dist_d    = dist_q;
    bcd_out_d = bcd_out_q;
    valid_d   = 1'b0;
    oor_d     = oor_q;

    case (state_q)
      StIdle: begin
        if (i_dist_valid) begin
          sample_d = i_distance;
          state_d  = StUpdate;
        end
      end
      StUpdate: begin
        if (!in_range) begin
          oor_d   = 1'b1;
          state_d = StIdle;
        end else begin
          oor_d           = 1'b0;
          sum_d           = sum_upd;
          buf_d[wr_ptr_q] = sample_q;
          wr_ptr_d        = wr_ptr_q + 1'b1;
          count_d         = count_upd;
          filt_d          = filt_upd;
          bin_d           = filt_upd;
          bcd_d           = '0;
          iter_d          = '0;
          state_d         = StConvert;
        end
      end
      StConvert: begin
        bcd_d  = bcd_sh;
        bin_d  = bin_sh;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd11) state_d = StDone;
      end
      StDone: begin
        dist_d    = filt_q;
        bcd_out_d = bcd_q;
        valid_d   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sample_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) buf_q[i] <= '0;
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      filt_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      dist_q    <= '0;
      bcd_out_q <= '0;
      valid_q   <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      buf_q     <= buf_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      filt_q    <= filt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      dist_q    <= dist_d;
      bcd_out_q <= bcd_out_d;
      valid_q   <= valid_d;
      oor_q     <= oor_d;
    end
  end

  assign o_distance     = dist_q;
  assign o_bcd          = bcd_out_q;
  assign o_valid        = valid_q;
  assign o_busy         = (state_q != StIdle);
  assign o_out_of_range = oor_q;

endmodule

// File: tb/tb_sr04_distance_filter.sv
// Directed plus randomized bench for sr04_distance_filter with a queue-based
// moving-average reference model.
module tb_sr04_distance_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_dist_valid = 1'b0;
  logic [11:0] i_distance = '0;
  logic [11:0] o_distance;
  logic [15:0] o_bcd;
  logic        o_valid;
  logic        o_busy;
  logic        o_out_of_range;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          win[$];
  logic [11:0] exp_dist = '0;
  logic [15:0] exp_bcd = '0;
  logic        exp_oor = 1'b0;

  sr04_distance_filter dut (
    .clk            (clk),
    .reset          (reset),
    .i_dist_valid   (i_dist_valid),
    .i_distance     (i_distance),
    .o_distance     (o_distance),
    .o_bcd          (o_bcd),
    .o_valid        (o_valid),
    .o_busy         (o_busy),
    .o_out_of_range (o_out_of_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    win.delete();
    exp_dist = '0;
    exp_bcd  = '0;
    exp_oor  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One strobe at edge 0; optionally a second strobe at edge drop_at (2..13) that must be dropped.
  task automatic do_sample(input logic [11:0] d, input int drop_at, input logic [11:0] drop_val);
    int sum;
    int f;
    @(negedge clk);
    i_dist_valid = 1'b1;
    i_distance   = d;
    @(posedge clk); #1;
    i_dist_valid = 1'b0;
    chk("busy_edge0", o_busy, 1);
    @(posedge clk); #1;
    if (d < 2 || d > 400) begin
      exp_oor = 1'b1;
      chk("oor_set", o_out_of_range, 1);
      chk("busy_after_reject", o_busy, 0);
      chk("no_valid_reject", o_valid, 0);
      chk("dist_hold_reject", o_distance, exp_dist);
      chk("bcd_hold_reject", o_bcd, exp_bcd);
    end else begin
      win.push_back(int'(d));
      if (win.size() > 4) void'(win.pop_front());
      if (win.size() < 4) f = int'(d);
      else begin
        sum = win[0] + win[1] + win[2] + win[3];
        f = sum / 4;
      end
      exp_oor = 1'b0;
      chk("oor_clear", o_out_of_range, 0);
      chk("busy_edge1", o_busy, 1);
      for (int e = 2; e <= 13; e++) begin
        if (e == drop_at) begin
          @(negedge clk);
          i_dist_valid = 1'b1;
          i_distance   = drop_val;
        end
        @(posedge clk); #1;
        i_dist_valid = 1'b0;
        chk("busy_novalid_conv", {o_busy, o_valid}, 2'b10);
      end
      @(posedge clk); #1;
      exp_dist = 12'(f);
      exp_bcd  = to_bcd(f);
      chk("valid_edge14", o_valid, 1);
      chk("dist_edge14", o_distance, exp_dist);
      chk("bcd_edge14", o_bcd, exp_bcd);
      chk("busy_edge14", o_busy, 0);
      @(posedge clk); #1;
      chk("valid_drop", o_valid, 0);
    end
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_after", {o_busy, o_valid, o_out_of_range}, {2'b00, exp_oor});
    end
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("rst_dist", o_distance, 0);
    chk("rst_bcd", o_bcd, 16'h0000);
    chk("rst_flags", {o_valid, o_busy, o_out_of_range}, 3'b000);

    // Single strobe
    do_sample(12'd100, 0, '0);
    chk("single_bcd", o_bcd, 16'h0100);

    // Window fill then averaging
    do_reset();
    do_sample(12'd100, 0, '0);
    do_sample(12'd200, 0, '0);
    do_sample(12'd300, 0, '0);
    do_sample(12'd400, 0, '0);
    chk("avg4_bcd", o_bcd, 16'h0250);
    do_sample(12'd8, 0, '0);
    chk("avg5_bcd", o_bcd, 16'h0227);

    // Range boundaries
    do_sample(12'd500, 0, '0);
    chk("reject_500_dist", o_distance, 227);
    do_sample(12'd1, 0, '0);
    chk("reject_1_flag", o_out_of_range, 1);
    do_sample(12'd2, 0, '0);
    chk("accept_2_flag", o_out_of_range, 0);

    // Strobe while busy is dropped
    do_sample(12'd50, 5, 12'd333);
    chk("drop_dist", o_distance, 115);

    // Randomized samples against the model
    for (int n = 0; n < 30; n++) begin
      logic [11:0] d;
      logic [11:0] dv;
      int          da;
      d  = 12'($urandom_range(0, 460));
      dv = 12'($urandom_range(0, 4095));
      da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 13)) : 0;
      do_sample(d, da, dv);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    // Make sure flags and outputs are non-zero going into the reset test
    do_sample(12'd321, 0, '0);
    do_sample(12'd4000, 0, '0);

    // Reset in the middle of a conversion
    @(negedge clk);
    i_dist_valid = 1'b1;
    i_distance   = 12'd123;
    @(posedge clk); #1;
    i_dist_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_dist", o_distance, 0);
    chk("midrst_bcd", o_bcd, 0);
    chk("midrst_flags", {o_valid, o_busy, o_out_of_range}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (16) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", {o_valid, o_busy}, 2'b00);
    end
    do_sample(12'd4095, 0, '0);
    chk("post_rst_reject", o_out_of_range, 1);
    do_sample(12'd400, 0, '0);
    chk("post_rst_bcd", o_bcd, 16'h0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
